// File: rtl/qpsk_demod.sv
// ---------------------------------------------------------------------------
// qpsk_demod
//
// Coherent QPSK demodulator. Each qualified sample is mixed with the local
// I/Q carriers, integrated over one symbol of SPS samples, and dumped. The
// sign of each integral gives the decided dibit.
//
// Pipeline (one qualified sample per cycle at most):
//   stage 1 : registers din*carrier_I, din*carrier_Q plus first/last tags
//   stage 2 : accumulates; on a last-tagged product captures acc+product
//   stage 3 : drives soft_I/soft_Q/dibit and the dibit_valid strobe
// dibit_valid therefore rises on the second edge after the edge that samples
// the last sample of a symbol.
//
// Ports
//   clk_fs       in   sample clock
//   rst          in   synchronous active-high reset
//   din_valid    in   qualifies din, carrier_I, carrier_Q, sym_start
//   din          in   [15:0] received sample, signed
//   carrier_I    in   [15:0] local cosine, signed
//   carrier_Q    in   [15:0] local quadrature carrier, signed
//   sym_start    in   marks a qualified sample as sample 0 of a symbol
//   dibit        out  [1:0] {I bit, Q bit}, 1 = negative integral
//   dibit_valid  out  one-cycle strobe, dibit/soft_I/soft_Q updated
//   soft_I       out  [41:0] signed I integral
//   soft_Q       out  [41:0] signed Q integral
//   resync       out  one-cycle strobe, partial symbol discarded
//   locked       out  high in INTEG state (exposes the FSM state)
//
// Handshake: a sample is consumed on every clk_fs edge where din_valid=1;
// there is no backpressure. Cycles with din_valid=0 are invisible to the
// symbol timing. Output strobes are single-cycle and carry no ready.
// ---------------------------------------------------------------------------
module qpsk_demod #(
    parameter int SPS = 16
) (
    input  logic               clk_fs,
    input  logic               rst,
    input  logic               din_valid,
    input  logic signed [15:0] din,
    input  logic signed [15:0] carrier_I,
    input  logic signed [15:0] carrier_Q,
    input  logic               sym_start,
    output logic [1:0]         dibit,
    output logic               dibit_valid,
    output logic signed [41:0] soft_I,
    output logic signed [41:0] soft_Q,
    output logic               resync,
    output logic               locked
);

    localparam int CW = (SPS > 1) ? $clog2(SPS) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(SPS - 1);

    typedef enum logic {
        ST_WAIT_SYNC = 1'b0,
        ST_INTEG     = 1'b1
    } state_t;

    state_t                r_state;
    logic [CW-1:0]         r_cnt;

    // stage 1
    logic                  r_p_v;
    logic                  r_p_first;
    logic                  r_p_last;
    logic signed [31:0]    r_prod_I;
    logic signed [31:0]    r_prod_Q;

    // stage 2
    logic signed [41:0]    r_acc_I;
    logic signed [41:0]    r_acc_Q;
    logic signed [41:0]    r_sum_I;
    logic signed [41:0]    r_sum_Q;
    logic                  r_d_v;

    logic                  w_take;
    logic                  w_resync;
    logic [CW-1:0]         w_idx;
    logic                  w_first;
    logic                  w_last;
    logic [CW-1:0]         w_cnt_next;
    logic signed [31:0]    w_prod_I;
    logic signed [31:0]    w_prod_Q;
    logic signed [41:0]    w_base_I;
    logic signed [41:0]    w_base_Q;
    logic signed [41:0]    w_new_I;
    logic signed [41:0]    w_new_Q;

    // A sample is taken in INTEG on any qualified cycle; in WAIT_SYNC only
    // when it carries sym_start.
    assign w_take   = din_valid && ((r_state == ST_INTEG) || sym_start);
    assign w_resync = din_valid && sym_start && (r_state == ST_INTEG) && (r_cnt != '0);

    // Index of the sample being taken: sym_start (or acquisition) forces 0.
    assign w_idx      = ((r_state == ST_WAIT_SYNC) || sym_start) ? '0 : r_cnt;
    assign w_first    = (w_idx == '0);
    assign w_last     = (w_idx == LAST_IDX);
    assign w_cnt_next = w_last ? '0 : (w_idx + CW'(1));

    // 32-bit operands keep -32768*-32768 = 2^30 exact.
    assign w_prod_I = 32'(din) * 32'(carrier_I);
    assign w_prod_Q = 32'(din) * 32'(carrier_Q);

    // A first-tagged product starts a fresh integral; this also discards any
    // partial sum left behind by a resync.
    assign w_base_I = r_p_first ? '0 : r_acc_I;
    assign w_base_Q = r_p_first ? '0 : r_acc_Q;
    assign w_new_I  = w_base_I + 42'(r_prod_I);
    assign w_new_Q  = w_base_Q + 42'(r_prod_Q);

    // FSM, sample counter and stage 1.
    always_ff @(posedge clk_fs) begin
        if (rst) begin
            r_state   <= ST_WAIT_SYNC;
            r_cnt     <= '0;
            locked    <= 1'b0;
            resync    <= 1'b0;
            r_p_v     <= 1'b0;
            r_p_first <= 1'b0;
            r_p_last  <= 1'b0;
            r_prod_I  <= '0;
            r_prod_Q  <= '0;
        end else begin
            resync <= w_resync;
            r_p_v  <= w_take;
            if (w_take) begin
                r_state   <= ST_INTEG;
                locked    <= 1'b1;
                r_cnt     <= w_cnt_next;
                r_p_first <= w_first;
                r_p_last  <= w_last;
                r_prod_I  <= w_prod_I;
                r_prod_Q  <= w_prod_Q;
            end
        end
    end

    // Stage 2: integrate and dump.
    always_ff @(posedge clk_fs) begin
        if (rst) begin
            r_acc_I <= '0;
            r_acc_Q <= '0;
            r_sum_I <= '0;
            r_sum_Q <= '0;
            r_d_v   <= 1'b0;
        end else begin
            r_d_v <= r_p_v && r_p_last;
            if (r_p_v) begin
                if (r_p_last) begin
                    r_sum_I <= w_new_I;
                    r_sum_Q <= w_new_Q;
                    r_acc_I <= '0;
                    r_acc_Q <= '0;
                end else begin
                    r_acc_I <= w_new_I;
                    r_acc_Q <= w_new_Q;
                end
            end
        end
    end

    // Stage 3: outputs hold until the next dump.
    always_ff @(posedge clk_fs) begin
        if (rst) begin
            dibit_valid <= 1'b0;
            dibit       <= 2'b00;
            soft_I      <= '0;
            soft_Q      <= '0;
        end else begin
            dibit_valid <= r_d_v;
            if (r_d_v) begin
                soft_I <= r_sum_I;
                soft_Q <= r_sum_Q;
                // Sign bit decides; an exact zero decides 0.
                dibit  <= {r_sum_I[41], r_sum_Q[41]};
            end
        end
    end

endmodule

// File: tb/tb_qpsk_demod.sv
// ---------------------------------------------------------------------------
// tb_qpsk_demod
//
// Directed bench. Three instances share one stimulus stream: SPS=4 (main
// function), SPS=1 (every sample is a whole symbol) and SPS=1024 (full-scale
// integration). Inputs change and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_qpsk_demod;

    logic               clk;
    logic               rst;
    logic               din_valid;
    logic signed [15:0] din;
    logic signed [15:0] carrier_I;
    logic signed [15:0] carrier_Q;
    logic               sym_start;

    logic [1:0]         dibit4, dibit1, dibitk;
    logic               dv4, dv1, dvk;
    logic signed [41:0] sI4, sQ4, sI1, sQ1, sIk, sQk;
    logic               rs4, rs1, rsk;
    logic               lk4, lk1, lkk;

    int n_checks = 0;
    int n_err    = 0;

    logic signed [15:0] dsym [3];
    longint             exp_s [3];
    logic [1:0]         exp_d [3];
    logic signed [15:0] min16;
    longint             p40;
    longint             prod;
    logic               exp_dv;

    qpsk_demod #(.SPS(4)) u_dut4 (
        .clk_fs(clk), .rst(rst), .din_valid(din_valid), .din(din),
        .carrier_I(carrier_I), .carrier_Q(carrier_Q), .sym_start(sym_start),
        .dibit(dibit4), .dibit_valid(dv4), .soft_I(sI4), .soft_Q(sQ4),
        .resync(rs4), .locked(lk4)
    );

    qpsk_demod #(.SPS(1)) u_dut1 (
        .clk_fs(clk), .rst(rst), .din_valid(din_valid), .din(din),
        .carrier_I(carrier_I), .carrier_Q(carrier_Q), .sym_start(sym_start),
        .dibit(dibit1), .dibit_valid(dv1), .soft_I(sI1), .soft_Q(sQ1),
        .resync(rs1), .locked(lk1)
    );

    qpsk_demod #(.SPS(1024)) u_dutk (
        .clk_fs(clk), .rst(rst), .din_valid(din_valid), .din(din),
        .carrier_I(carrier_I), .carrier_Q(carrier_Q), .sym_start(sym_start),
        .dibit(dibitk), .dibit_valid(dvk), .soft_I(sIk), .soft_Q(sQk),
        .resync(rsk), .locked(lkk)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic put(input logic ss, input logic signed [15:0] d,
                       input logic signed [15:0] ci, input logic signed [15:0] cq);
        din_valid = 1'b1;
        sym_start = ss;
        din       = d;
        carrier_I = ci;
        carrier_Q = cq;
        @(negedge clk);
        din_valid = 1'b0;
        sym_start = 1'b0;
    endtask

    task automatic idle(input int n);
        din_valid = 1'b0;
        sym_start = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // scoreboard compare
    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        dsym[0] = 16'sd1000;  exp_s[0] = 64'sd4000000;  exp_d[0] = 2'b00;
        dsym[1] = -16'sd1000; exp_s[1] = -64'sd4000000; exp_d[1] = 2'b11;
        dsym[2] = 16'sd7;     exp_s[2] = 64'sd28000;    exp_d[2] = 2'b00;
        min16 = 16'sh8000;
        p40   = 64'sd1 <<< 40;

        rst = 1'b1; din_valid = 1'b0; sym_start = 1'b0;
        din = '0; carrier_I = '0; carrier_Q = '0;
        @(negedge clk);
        @(negedge clk);

        // reset state
        chk("rst_dv",     dv4, 0);
        chk("rst_dibit",  dibit4, 0);
        chk("rst_softI",  sI4, 0);
        chk("rst_softQ",  sQ4, 0);
        chk("rst_resync", rs4, 0);
        chk("rst_locked", lk4, 0);
        chk("rst_locked_k", lkk, 0);
        rst = 1'b0;

        // samples without sym_start are ignored in WAIT_SYNC
        put(1'b0, 16'sd1000, 16'sd1000, 16'sd1000);
        put(1'b0, 16'sd1000, 16'sd1000, 16'sd1000);
        chk("wait_locked4", lk4, 0);
        chk("wait_locked1", lk1, 0);
        idle(3);
        chk("wait_dv4", dv4, 0);
        chk("wait_dv1", dv1, 0);

        // basic symbol: soft_I=4e6, soft_Q=-4e6, dibit 01
        put(1'b1, 16'sd1000, 16'sd1000, -16'sd1000);
        chk("t1_locked", lk4, 1);
        put(1'b0, 16'sd1000, 16'sd1000, -16'sd1000);
        put(1'b0, 16'sd1000, 16'sd1000, -16'sd1000);
        put(1'b0, 16'sd1000, 16'sd1000, -16'sd1000);
        idle(1);
        chk("t1_dv_e1", dv4, 0);
        idle(1);
        chk("t1_dv_e2", dv4, 1);
        chk("t1_softI", sI4, 64'sd4000000);
        chk("t1_softQ", sQ4, -64'sd4000000);
        chk("t1_dibit", dibit4, 2'b01);
        chk("t1_resync", rs4, 0);
        idle(1);
        chk("t1_dv_e3", dv4, 0);
        chk("t1_hold_softI", sI4, 64'sd4000000);

        // idle gaps between samples are transparent
        for (int s = 0; s < 4; s++) begin
            put(s == 0, 16'(100 * (s + 1)), -16'sd1000, 16'sd50);
            if (s < 3) begin
                idle(3);
                chk("t2_gap_dv", dv4, 0);
            end
        end
        idle(1);
        chk("t2_dv_e1", dv4, 0);
        idle(1);
        chk("t2_dv_e2", dv4, 1);
        chk("t2_softI", sI4, -64'sd1000000);
        chk("t2_softQ", sQ4, 64'sd50000);
        chk("t2_dibit", dibit4, 2'b10);
        idle(1);

        // sym_start on the 3rd sample discards the partial symbol
        put(1'b1, 16'sd500, 16'sd500, 16'sd500);
        put(1'b0, 16'sd500, 16'sd500, 16'sd500);
        chk("t3_resync_pre", rs4, 0);
        put(1'b1, 16'sd1000, -16'sd10, 16'sd20);
        chk("t3_resync", rs4, 1);
        chk("t3_resync_sps1", rs1, 0);
        chk("t3_dv_a", dv4, 0);
        for (int s = 0; s < 3; s++) begin
            put(1'b0, 16'sd1000, -16'sd10, 16'sd20);
            chk("t3_resync_off", rs4, 0);
            chk("t3_dv_partial", dv4, 0);
        end
        idle(1);
        chk("t3_dv_e1", dv4, 0);
        idle(1);
        chk("t3_dv_e2", dv4, 1);
        chk("t3_softI", sI4, -64'sd40000);
        chk("t3_softQ", sQ4, 64'sd80000);
        chk("t3_dibit", dibit4, 2'b10);
        idle(1);
        chk("t3_dv_e3", dv4, 0);

        // back-to-back symbols with alternating sign; SPS=1 checked per sample
        for (int n = 0; n < 14; n++) begin
            if (n < 12) put(n % 4 == 0, dsym[n / 4], 16'sd1000, 16'sd1000);
            else idle(1);
            exp_dv = (n == 5) || (n == 9) || (n == 13);
            chk("t4_dv", dv4, exp_dv);
            chk("t4_resync", rs4, 0);
            if (exp_dv) begin
                chk("t4_softI", sI4, exp_s[(n - 5) / 4]);
                chk("t4_softQ", sQ4, exp_s[(n - 5) / 4]);
                chk("t4_dibit", dibit4, exp_d[(n - 5) / 4]);
            end
            chk("t4_sps1_dv", dv1, n >= 2);
            if (n >= 2) begin
                prod = longint'(dsym[(n - 2) / 4]) * 1000;
                chk("t4_sps1_softI", sI1, prod);
                chk("t4_sps1_softQ", sQ1, prod);
                chk("t4_sps1_dibit", dibit1, (prod < 0) ? 2'b11 : 2'b00);
            end
        end
        idle(1);

        // reset on the edge after the last sample drops the symbol
        put(1'b1, 16'sd1000, 16'sd1000, 16'sd1000);
        put(1'b0, 16'sd1000, 16'sd1000, 16'sd1000);
        put(1'b0, 16'sd1000, 16'sd1000, 16'sd1000);
        put(1'b0, 16'sd1000, 16'sd1000, 16'sd1000);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("t5_dv", dv4, 0);
        chk("t5_locked", lk4, 0);
        chk("t5_softI", sI4, 0);
        chk("t5_softQ", sQ4, 0);
        chk("t5_dibit", dibit4, 0);
        chk("t5_resync_k", rsk, 0);
        idle(1);
        chk("t5_dv_after", dv4, 0);
        idle(2);
        chk("t5_dv_late", dv4, 0);
        put(1'b0, 16'sd1000, 16'sd1000, 16'sd1000);
        put(1'b0, 16'sd1000, 16'sd1000, 16'sd1000);
        put(1'b0, 16'sd1000, 16'sd1000, 16'sd1000);
        chk("t5_ignore_lk4", lk4, 0);
        chk("t5_ignore_lk1", lk1, 0);
        chk("t5_ignore_lkk", lkk, 0);
        idle(2);
        chk("t5_ignore_dv1", dv1, 0);

        // SPS=1024 at full negative scale; first sym_start restarts acquisition
        put(1'b1, min16, min16, min16);
        chk("t6_restart_lk4", lk4, 1);
        chk("t6_restart_lkk", lkk, 1);
        for (int s = 1; s < 1024; s++) put(1'b0, min16, min16, min16);
        idle(1);
        chk("t6_dv_e1", dvk, 0);
        idle(1);
        chk("t6_dv_e2", dvk, 1);
        chk("t6_softI", sIk, p40);
        chk("t6_softQ", sQk, p40);
        chk("t6_dibit", dibitk, 2'b00);
        chk("t6_sps4_dv", dv4, 1);
        chk("t6_sps4_softI", sI4, 64'sd4294967296);
        idle(1);
        chk("t6_dv_e3", dvk, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
